// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with pipeline-fill skip on channel 0, wrap/saturate
// mode, sticky overflow, freeze-on-halt and a registered readout mux.
module perf_counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int FILL_SKIP = 2,
  parameter int SAT_MODE  = 0,
  parameter int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              enable_i,
  input  logic              halt_i,
  input  logic              clear_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [CNT_W-1:0]  count0_o,
  output logic [NUM_CH-1:0] ovf_o,
  output logic              frozen_o
);

  localparam int SKIP_W = (FILL_SKIP > 0) ? $clog2(FILL_SKIP + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(FILL_SKIP);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_t;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt  [NUM_CH];
  logic [CNT_W:0]    bump_v   [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_nxt;
  logic [SKIP_W-1:0] skip_q, skip_nxt;
  logic [CNT_W-1:0]  rd_mux;
  logic              count_en;

  // Increment with wrap or saturation; MSB of the result flags an overflow event.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] at_top;
    if (SAT_MODE != 0) at_top = CNT_MAX;
    else               at_top = '0;
    if (c == CNT_MAX) return {1'b1, at_top};
    else              return {1'b0, c + CNT_W'(1)};
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= RUN;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      RUN:     if (halt_i && !clear_i) state_nxt = FROZEN;
      FROZEN:  if (clear_i)            state_nxt = RUN;
      default:                         state_nxt = RUN;
    endcase
  end

  always_comb begin
    frozen_o = (state_q == FROZEN);
    count_en = (state_q == RUN) && enable_i && !clear_i;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) bump_v[i] = bump(cnt_q[i]);
  end

  // Channel 0 events are swallowed by the skip counter until the pipeline has filled.
  always_comb begin
    skip_nxt = skip_q;
    ovf_nxt  = ovf_q;
    for (int i = 0; i < NUM_CH; i++) cnt_nxt[i] = cnt_q[i];
    if (clear_i) begin
      skip_nxt = SKIP_INIT;
      ovf_nxt  = '0;
      for (int i = 0; i < NUM_CH; i++) cnt_nxt[i] = '0;
    end else if (count_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (event_i[i]) begin
          if (i == 0 && skip_q != '0) begin
            skip_nxt = skip_q - SKIP_W'(1);
          end else begin
            cnt_nxt[i] = bump_v[i][CNT_W-1:0];
            if (bump_v[i][CNT_W]) ovf_nxt[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel_i == SEL_W'(i)) rd_mux = cnt_q[i];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      ovf_q     <= '0;
      skip_q    <= SKIP_INIT;
      rd_data_o <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_nxt[i];
      ovf_q     <= ovf_nxt;
      skip_q    <= skip_nxt;
      rd_data_o <= rd_mux;
    end
  end

  assign count0_o = cnt_q[0];
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three instances (16-bit wrap, 4-bit wrap, 4-bit saturate)
// share one stimulus stream and are checked against an event-count model every cycle.
module tb_perf_counter_bank;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] ev;
  logic       en, halt, clr;
  logic [2:0] sel;

  logic [15:0] rd_w, c0_w;
  logic [3:0]  rd_a, c0_a, rd_s, c0_s;
  logic [3:0]  ovf_w, ovf_a, ovf_s;
  logic        fz_w, fz_a, fz_s;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  perf_counter_bank #(.NUM_CH(4), .CNT_W(16), .FILL_SKIP(2), .SAT_MODE(0), .SEL_W(3)) dut_w (
    .Clk(Clk), .Reset(Reset), .event_i(ev), .enable_i(en), .halt_i(halt), .clear_i(clr),
    .rd_sel_i(sel), .rd_data_o(rd_w), .count0_o(c0_w), .ovf_o(ovf_w), .frozen_o(fz_w));

  perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .FILL_SKIP(2), .SAT_MODE(0), .SEL_W(3)) dut_a (
    .Clk(Clk), .Reset(Reset), .event_i(ev), .enable_i(en), .halt_i(halt), .clear_i(clr),
    .rd_sel_i(sel), .rd_data_o(rd_a), .count0_o(c0_a), .ovf_o(ovf_a), .frozen_o(fz_a));

  perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .FILL_SKIP(2), .SAT_MODE(1), .SEL_W(3)) dut_s (
    .Clk(Clk), .Reset(Reset), .event_i(ev), .enable_i(en), .halt_i(halt), .clear_i(clr),
    .rd_sel_i(sel), .rd_data_o(rd_s), .count0_o(c0_s), .ovf_o(ovf_s), .frozen_o(fz_s));

  // Model: unbounded count of accepted events per channel, mapped to a counter value per instance.
  int n [4] = '{0, 0, 0, 0};
  int swallowed = 0;
  bit m_frozen = 1'b0;
  int exp_rd [3] = '{0, 0, 0};

  function automatic int wid(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic bit sat(input int k);
    return (k == 2);
  endfunction

  function automatic int expv(input int cnt, input int k);
    int mx;
    mx = (1 << wid(k)) - 1;
    if (sat(k)) return (cnt > mx) ? mx : cnt;
    return cnt % (mx + 1);
  endfunction

  function automatic int expovf(input int k);
    int r;
    r = 0;
    for (int c = 0; c < 4; c++) if (n[c] > (1 << wid(k)) - 1) r |= (1 << c);
    return r;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int c = 0; c < 4; c++) n[c] = 0;
      swallowed = 0;
      m_frozen  = 1'b0;
      for (int k = 0; k < 3; k++) exp_rd[k] = 0;
    end else begin
      for (int k = 0; k < 3; k++) exp_rd[k] = (int'(sel) < 4) ? expv(n[int'(sel)], k) : 0;
      if (clr) begin
        for (int c = 0; c < 4; c++) n[c] = 0;
        swallowed = 0;
        m_frozen  = 1'b0;
      end else if (!m_frozen) begin
        if (en) begin
          for (int c = 0; c < 4; c++) begin
            if (ev[c]) begin
              if (c == 0 && swallowed < 2) swallowed++;
              else n[c]++;
            end
          end
        end
        if (halt) m_frozen = 1'b1;
      end
    end
  end

  int a_c0 [3], a_rd [3], a_ovf [3], a_fz [3];
  always_comb begin
    a_c0[0] = int'(c0_w);  a_c0[1] = int'(c0_a);  a_c0[2] = int'(c0_s);
    a_rd[0] = int'(rd_w);  a_rd[1] = int'(rd_a);  a_rd[2] = int'(rd_s);
    a_ovf[0] = int'(ovf_w); a_ovf[1] = int'(ovf_a); a_ovf[2] = int'(ovf_s);
    a_fz[0] = int'(fz_w);  a_fz[1] = int'(fz_a);  a_fz[2] = int'(fz_s);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("count0[%0d]", k), a_c0[k], expv(n[0], k));
        chk($sformatf("ovf[%0d]", k), a_ovf[k], expovf(k));
        chk($sformatf("frozen[%0d]", k), a_fz[k], int'(m_frozen));
        chk($sformatf("rd_data[%0d]", k), a_rd[k], exp_rd[k]);
      end
    end
  end

  task automatic step(input logic [3:0] e, input logic ena, input logic h,
                      input logic c, input logic [2:0] s);
    ev = e; en = ena; halt = h; clr = c; sel = s;
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Reset = 1'b1; ev = 4'b0; en = 1'b0; halt = 1'b0; clr = 1'b0; sel = 3'd0;
    #12;
    chk("reset_count0", int'(c0_w), 0);
    chk("reset_rd", int'(rd_w), 0);
    Reset = 1'b0;

    // Pipeline-fill skip: 5 events, first 2 discarded.
    repeat (5) step(4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("fill_count0", int'(c0_w), 3);
    chk("fill_ovf", int'(ovf_w), 0);

    // Wrap vs saturate on channel 1.
    step(4'b0000, 1'b1, 1'b0, 1'b1, 3'd1);
    repeat (17) step(4'b0010, 1'b1, 1'b0, 1'b0, 3'd1);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 3'd1);
    chk("wrap_ch1", int'(rd_a), 1);
    chk("wrap_ovf", int'(ovf_a), 4'b0010);
    chk("sat_ch1", int'(rd_s), 15);
    chk("sat_ovf", int'(ovf_s), 4'b0010);
    chk("wide_ch1", int'(rd_w), 17);
    chk("wide_ovf", int'(ovf_w), 0);

    // Halt with events in the same cycle, then events ignored while frozen.
    step(4'b0000, 1'b1, 1'b0, 1'b1, 3'd3);
    repeat (2) step(4'b0001, 1'b1, 1'b0, 1'b0, 3'd3);
    step(4'b1111, 1'b1, 1'b1, 1'b0, 3'd3);
    repeat (10) step(4'b1111, 1'b1, 1'b0, 1'b0, 3'd3);
    chk("frozen_flag", int'(fz_w), 1);
    chk("frozen_count0", int'(c0_a), 1);
    chk("frozen_ch3", int'(rd_s), 1);

    // Clear out of FROZEN with halt held; skip reloaded.
    step(4'b1111, 1'b1, 1'b1, 1'b1, 3'd0);
    chk("unfreeze_flag", int'(fz_w), 0);
    chk("unfreeze_count0", int'(c0_w), 0);
    repeat (2) step(4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("reskip_count0", int'(c0_w), 0);
    step(4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("reskip_count0_after", int'(c0_w), 1);

    // Enable low holds counters but halt still freezes.
    repeat (2) step(4'b1111, 1'b0, 1'b0, 1'b0, 3'd0);
    step(4'b1111, 1'b0, 1'b1, 1'b0, 3'd0);
    chk("en_off_frozen", int'(fz_a), 1);
    chk("en_off_count0", int'(c0_a), 1);

    // Readout latency and out-of-range select.
    step(4'b0000, 1'b1, 1'b0, 1'b1, 3'd2);
    repeat (7) step(4'b0100, 1'b1, 1'b0, 1'b0, 3'd2);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 3'd2);
    chk("rd_ch2", int'(rd_w), 7);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 3'd5);
    chk("rd_oob", int'(rd_w), 0);

    // Asynchronous reset between edges while frozen with nonzero counts.
    step(4'b0000, 1'b1, 1'b0, 1'b1, 3'd1);
    repeat (3) step(4'b1111, 1'b1, 1'b0, 1'b0, 3'd1);
    step(4'b1111, 1'b1, 1'b1, 1'b0, 3'd1);
    #1 Reset = 1'b1;
    #1;
    chk("async_count0", int'(c0_w), 0);
    chk("async_rd", int'(rd_w), 0);
    chk("async_frozen", int'(fz_w), 0);
    chk("async_ovf", int'(ovf_a), 0);
    ev = 4'b0; halt = 1'b0;
    #20 Reset = 1'b0;
    repeat (3) step(4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("post_reset_count0", int'(c0_w), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
